// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int ISIZE = 32;
    localparam int DSIZE = 32;
    localparam logic [ISIZE-1:0] PC_INC = 32'd4;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [ISIZE-1:0] align_word(input logic [ISIZE-1:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// In-order buffer of fetched instructions: entries are allocated at request time
// and filled when the matching response returns.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  alloc,
    input  logic [ISIZE-1:0]      alloc_pc,
    input  logic                  fill,
    input  logic [DSIZE-1:0]      fill_data,
    input  logic                  pop,
    output logic                  full,
    output logic                  head_filled,
    output logic [ISIZE-1:0]      head_pc,
    output logic [DSIZE-1:0]      head_data,
    output logic [$clog2(DEPTH):0] unfilled_cnt,
    output logic                  has_unfilled
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ISIZE-1:0] pc_q   [DEPTH];
    logic [ISIZE-1:0] pc_d   [DEPTH];
    logic [DSIZE-1:0] data_q [DEPTH];
    logic [DSIZE-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    fill_ptr_q, fill_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    unfilled_q, unfilled_d;

    assign full         = (cnt_q == CW'(DEPTH));
    assign head_filled  = filled_q[head_q];
    assign head_pc      = pc_q[head_q];
    assign head_data    = data_q[head_q];
    assign unfilled_cnt = unfilled_q;
    assign has_unfilled = (unfilled_q != {CW{1'b0}});

    // Per-entry next state; fills always land on the oldest unfilled entry.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc && !flush && (tail_q == PW'(i))) begin
                pc_d[i] = alloc_pc;
            end else begin
                pc_d[i] = pc_q[i];
            end
            if (fill && !flush && (fill_ptr_q == PW'(i))) begin
                data_d[i] = fill_data;
            end else begin
                data_d[i] = data_q[i];
            end
            if (flush) begin
                filled_d[i] = 1'b0;
            end else if (fill && (fill_ptr_q == PW'(i))) begin
                filled_d[i] = 1'b1;
            end else if ((alloc && (tail_q == PW'(i))) || (pop && (head_q == PW'(i)))) begin
                filled_d[i] = 1'b0;
            end else begin
                filled_d[i] = filled_q[i];
            end
        end
    end

    // Pointer and occupancy next state.
    always_comb begin
        if (flush) begin
            head_d     = {PW{1'b0}};
            tail_d     = {PW{1'b0}};
            fill_ptr_d = {PW{1'b0}};
            cnt_d      = {CW{1'b0}};
            unfilled_d = {CW{1'b0}};
        end else begin
            head_d     = head_q + PW'(pop);
            tail_d     = tail_q + PW'(alloc);
            fill_ptr_d = fill_ptr_q + PW'(fill);
            cnt_d      = cnt_q + CW'(alloc) - CW'(pop);
            unfilled_d = unfilled_q + CW'(alloc) - CW'(fill);
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= {ISIZE{1'b0}};
                data_q[i] <= {DSIZE{1'b0}};
            end
            filled_q   <= {DEPTH{1'b0}};
            head_q     <= {PW{1'b0}};
            tail_q     <= {PW{1'b0}};
            fill_ptr_q <= {PW{1'b0}};
            cnt_q      <= {CW{1'b0}};
            unfilled_q <= {CW{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= pc_d[i];
                data_q[i] <= data_d[i];
            end
            filled_q   <= filled_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_ptr_q <= fill_ptr_d;
            cnt_q      <= cnt_d;
            unfilled_q <= unfilled_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, memory request issue, stale-response
// dropping after redirects, and the decoder-side handshake.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ISIZE-1:0] RESET_PC   = 32'h0000_0000,
    parameter int               FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [ISIZE-1:0] imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [ISIZE-1:0] imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [ISIZE-1:0] instr,
    output logic [ISIZE-1:0] instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = $clog2(2 * FIFO_DEPTH) + 1;

    logic [ISIZE-1:0] pc_q, pc_d;
    logic [DW-1:0]    drop_cnt_q, drop_cnt_d;
    logic             run_q, run_d;

    logic             full_s;
    logic             head_filled_s;
    logic [CW-1:0]    unfilled_cnt_s;
    logic             has_unfilled_s;
    logic             req_fire_s;
    logic             fill_s;
    logic             pop_s;
    logic             dropping_s;
    logic [DW-1:0]    drop_sum_s;

    // run_q keeps the request line quiet for the cycle in which reset releases.
    assign imem_req_valid = run_q && !full_s && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign req_fire_s     = imem_req_valid && imem_req_ready;
    assign dropping_s     = (drop_cnt_q != {DW{1'b0}});
    assign fill_s         = imem_rsp_valid && !redirect_valid && !dropping_s && has_unfilled_s;
    assign pop_s          = head_filled_s && instr_ready && !redirect_valid;
    assign drop_sum_s     = drop_cnt_q + DW'(unfilled_cnt_s);

    fetch_buffer #(
        .DEPTH(FIFO_DEPTH)
    ) u_buf (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect_valid),
        .alloc       (req_fire_s),
        .alloc_pc    (pc_q),
        .fill        (fill_s),
        .fill_data   (imem_rsp_data),
        .pop         (pop_s),
        .full        (full_s),
        .head_filled (head_filled_s),
        .head_pc     (instr_pc),
        .head_data   (instr),
        .unfilled_cnt(unfilled_cnt_s),
        .has_unfilled(has_unfilled_s)
    );

    assign instr_valid = head_filled_s;

    // PC and drop counter next state; a redirect overrides everything else.
    always_comb begin
        run_d = 1'b1;
        if (redirect_valid) begin
            pc_d = align_word(redirect_pc);
            // Every in-flight response belongs to the old path; the one arriving now is discarded too.
            if (imem_rsp_valid && (drop_sum_s != {DW{1'b0}})) begin
                drop_cnt_d = drop_sum_s - DW'(1);
            end else begin
                drop_cnt_d = drop_sum_s;
            end
        end else begin
            if (req_fire_s) begin
                pc_d = pc_q + PC_INC;
            end else begin
                pc_d = pc_q;
            end
            if (imem_rsp_valid && dropping_s) begin
                drop_cnt_d = drop_cnt_q - DW'(1);
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
    end

    // Fetch control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            drop_cnt_q <= {DW{1'b0}};
            run_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
            run_q      <= run_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order instruction memory model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc)
    );

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; int cyc; } dlv_t;
    mreq_t mq[$];
    dlv_t  dq[$];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   lat = 1;
    int   rdy_mode = 0;
    int   hs_cnt = 0;
    logic last_hs = 1'b0;
    logic [31:0] exp_addr;

    always @(negedge clk) begin
        if (rst_n) begin
            assert (dut.drop_cnt_q <= 2 * DEPTH) else $error("drop counter overflow");
            assert (!(imem_rsp_valid && !redirect_valid && dut.drop_cnt_q == 0 && !dut.has_unfilled_s))
                else $error("response with no outstanding request");
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: sample handshakes, then drive memory response and ready for the new cycle.
    task automatic step();
        logic        hs;
        logic [31:0] a;
        #1;
        hs = imem_req_valid && imem_req_ready;
        a  = imem_req_addr;
        if (instr_valid && instr_ready && !redirect_valid) dq.push_back('{instr_pc, instr, cyc});
        @(posedge clk);
        #1;
        if (hs) begin
            mq.push_back('{a, cyc + lat});
            hs_cnt++;
        end
        last_hs = hs;
        cyc++;
        redirect_valid = 1'b0;
        imem_req_ready = (rdy_mode == 0) ? 1'b1 : ((cyc % 2) == 1);
        if (mq.size() > 0 && mq[0].due == cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mq[0].addr;
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
    endtask

    task automatic do_reset(input int l, input int mode);
        rst_n = 1'b0;
        #1;
        chk("rst_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        redirect_valid = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        instr_ready    = 1'b1;
        lat = l;
        rdy_mode = mode;
        mq.delete();
        dq.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        hs_cnt = 0;
        imem_req_ready = (mode == 0);
        #1;
    endtask

    task automatic wait_deliv(input int n, input int maxc, input string tag);
        for (int i = 0; i < maxc && dq.size() < n; i++) step();
        chk(tag, {31'h0, dq.size() >= n}, 32'h1);
    endtask

    initial begin
        // Reset state while rst_n is held low.
        #12;
        chk("reset_req_valid", {31'h0, imem_req_valid}, 32'h0);
        chk("reset_instr_valid", {31'h0, instr_valid}, 32'h0);
        chk("reset_instr", instr, 32'h0);
        chk("reset_instr_pc", instr_pc, 32'h0);
        chk("reset_req_addr", imem_req_addr, RPC);

        // Streaming with L=1, decoder always ready.
        do_reset(1, 0);
        step();
        chk("t1_c1_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("t1_c1_addr", imem_req_addr, 32'h100);
        step();
        chk("t1_c2_addr", imem_req_addr, 32'h104);
        chk("t1_c2_ivalid", {31'h0, instr_valid}, 32'h0);
        step();
        chk("t1_c3_addr", imem_req_addr, 32'h108);
        chk("t1_c3_ivalid", {31'h0, instr_valid}, 32'h1);
        chk("t1_c3_pc", instr_pc, 32'h100);
        chk("t1_c3_instr", instr, ~32'h100);
        repeat (5) step();
        chk("t1_ndeliv", dq.size(), 32'd5);
        chk("t1_nreq", hs_cnt, 32'd7);
        for (int i = 0; i < dq.size(); i++) begin
            chk("t1_seq_pc", dq[i].pc, 32'h100 + 32'(4 * i));
            chk("t1_seq_data", dq[i].data, ~(32'h100 + 32'(4 * i)));
        end

        // Decoder stalled: buffer fills, requests stop, then drains in order.
        do_reset(1, 0);
        instr_ready = 1'b0;
        repeat (10) step();
        chk("t2_nreq", hs_cnt, DEPTH);
        chk("t2_req_stop", {31'h0, imem_req_valid}, 32'h0);
        chk("t2_ivalid", {31'h0, instr_valid}, 32'h1);
        instr_ready = 1'b1;
        wait_deliv(8, 30, "t2_timeout");
        for (int i = 0; i < 8 && i < dq.size(); i++) begin
            chk("t2_seq_pc", dq[i].pc, 32'h100 + 32'(4 * i));
            chk("t2_seq_data", dq[i].data, ~(32'h100 + 32'(4 * i)));
        end

        // Memory ready only every other cycle.
        do_reset(1, 1);
        exp_addr = 32'h100;
        for (int i = 0; i < 12; i++) begin
            step();
            if (last_hs) exp_addr = exp_addr + 32'd4;
            chk("t3_addr", imem_req_addr, exp_addr);
        end
        chk("t3_nreq", hs_cnt, 32'd6);
        chk("t3_final_addr", imem_req_addr, 32'h118);

        // Redirect with two requests in flight, L=3.
        do_reset(3, 0);
        repeat (3) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        #1;
        chk("t4_req_blocked", {31'h0, imem_req_valid}, 32'h0);
        dq.delete();
        step();
        chk("t4_new_addr", imem_req_addr, 32'h200);
        chk("t4_req_valid", {31'h0, imem_req_valid}, 32'h1);
        chk("t4_ivalid", {31'h0, instr_valid}, 32'h0);
        wait_deliv(2, 20, "t4_timeout");
        if (dq.size() >= 2) begin
            chk("t4_first_pc", dq[0].pc, 32'h200);
            chk("t4_first_data", dq[0].data, ~32'h200);
            chk("t4_first_cyc", dq[0].cyc, 32'd8);
            chk("t4_second_pc", dq[1].pc, 32'h204);
        end

        // Redirect coinciding with a response and a pop, L=2.
        do_reset(2, 0);
        repeat (4) step();
        chk("t5_ivalid_pre", {31'h0, instr_valid}, 32'h1);
        chk("t5_pc_pre", instr_pc, 32'h100);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        dq.delete();
        #1;
        step();
        chk("t5_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
        chk("t5_ivalid", {31'h0, instr_valid}, 32'h0);
        chk("t5_addr", imem_req_addr, 32'h300);
        step();
        chk("t5_drop_cnt2", 32'(dut.drop_cnt_q), 32'd0);
        wait_deliv(1, 20, "t5_timeout");
        if (dq.size() >= 1) begin
            chk("t5_first_pc", dq[0].pc, 32'h300);
            chk("t5_first_data", dq[0].data, ~32'h300);
        end

        // PC wraps from the top of the address space.
        do_reset(1, 0);
        repeat (2) step();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        dq.delete();
        #1;
        step();
        chk("t6_addr_top", imem_req_addr, 32'hFFFF_FFFC);
        step();
        chk("t6_addr_wrap", imem_req_addr, 32'h0000_0000);
        wait_deliv(2, 20, "t6_timeout");
        if (dq.size() >= 2) begin
            chk("t6_pc0", dq[0].pc, 32'hFFFF_FFFC);
            chk("t6_pc1", dq[1].pc, 32'h0000_0000);
            chk("t6_data1", dq[1].data, 32'hFFFF_FFFF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
